seg7_scan: RTL and testbench
============================

Name: seg7_scan

Overview:
- Time-multiplexed driver for the board's eight common-anode 7-segment digits.
- Sits directly downstream of the display formatter: consumes eight 4-bit digit codes plus per-digit decimal-point and blank masks.
- Produces CA..CG, DP and AN[7:0] with active-low levels.
- Also provides whole-display blinking for the alarm, and snapshots its inputs once per frame so the display never shows a mix of two times.

Parameters:
- CLK_HZ, 100_000_000: input clock frequency.
- SCAN_HZ, 1000: digit-advance rate; one frame is 8 digits = 8 ms by default.
- BLINK_HZ, 2: blink rate; half-period = CLK_HZ/(2*BLINK_HZ) cycles.

Ports:
- clk, in, 1: system clock.
- reset_n, in, 1: asynchronous, active-low reset.
- digits, in, 32: digit i code in digits[4i+3:4i]; hex 0-F; digit 0 is the rightmost (AN[0]).
- dp_mask, in, 8: 1 lights the DP of digit i.
- blank_mask, in, 8: 1 forces digit i dark; its anode stays off.
- blink_en, in, 1: enables whole-display blinking.
- seg, out, 7: {CA,CB,CC,CD,CE,CF,CG}, active-low.
- dp, out, 1: decimal point, active-low.
- an, out, 8: anodes, active-low, at most one low at any time.
- frame_start, out, 1: one-cycle pulse when digit 0 becomes active.

Behaviour:
- Reset values (asynchronous, while reset_n=0):
  - outputs: an=8'hFF, seg=7'h7F, dp=1, frame_start=0.
  - internal: scan prescaler=0, idx=0, blink counter=0, blink_phase=0.
  - shadow registers: digits=0, dp_mask=0, blank_mask=8'hFF.
- Scan tick:
  - DIV = CLK_HZ/SCAN_HZ - 1. The prescaler counts 0..DIV; tick is high in the cycle where prescaler==DIV.
  - On the tick edge: prescaler->0, idx->(idx+1) mod 8 (7 wraps to 0).
- Snapshot:
  - On a tick with idx==7, shadow <= {digits, dp_mask, blank_mask}, sampled at that edge.
  - Inputs changing mid-frame have no effect until the next frame.
  - The first frame after reset is fully dark: shadow blank_mask=FF, and the first snapshot happens at the 8th tick.
- Output register (outputs lag idx by exactly 1 cycle):
  - If shadow_blank[idx]=1 or (blink_en & blink_phase): an=FF, seg=7F, dp=1.
  - Otherwise: an=~(8'b1<<idx), seg=HEX2SEG[shadow_digit[idx]], dp=~shadow_dp[idx].
  - frame_start=1 in the cycle the output register first presents idx=0. This is one cycle after the 7->0 tick; the first pulse comes after the 8th tick.
- Blink:
  - While blink_en=0: blink counter and blink_phase are held at 0, so the display is steady.
  - While blink_en=1: the counter runs; blink_phase toggles every CLK_HZ/(2*BLINK_HZ) cycles.
  - The first half-period after blink_en rises is visible (phase=0).
  - Blink gating affects only the output stage; scanning and snapshotting continue unchanged.
- Anti-ghosting: the anode and segment values for a digit change on the same edge, never split across cycles.
- Reset mid-frame returns immediately to all reset values; the blank first frame repeats.
- Parameter rules (elaboration error otherwise):
  - CLK_HZ % SCAN_HZ == 0 and DIV >= 1.
  - CLK_HZ % (2*BLINK_HZ) == 0.
- Counter widths: $clog2 of the respective terminal count + 1; no wrap other than the defined terminal counts.
- HEX2SEG (active-low, {a..g}):
  - 0:01 1:4F 2:12 3:06 4:4C 5:24 6:20 7:0F
  - 8:00 9:04 A:08 b:60 C:31 d:42 E:30 F:38

Decomposition:
- Package seg7_pkg:
  - HEX2SEG constant array (16 x 7 bits).
  - SEG_OFF = 7'h7F, AN_OFF = 8'hFF.
  - N_DIGITS = 8.
- Sub-module tick_gen #(PERIOD):
  - Ports: clk, reset_n, clr, tick.
  - Counter that pulses tick every PERIOD cycles; clr holds it at 0.
  - Instantiated twice: scan (PERIOD = DIV+1) and blink (PERIOD = half-period, clr = ~blink_en).
  - blink_phase toggles on the blink tick and is cleared while blink_en=0.

Test Plan (CLK_HZ=800, SCAN_HZ=100 -> DIV=7, frame=64 cycles; BLINK_HZ=10 -> half-period 40 cycles):
- Reset: assert reset_n=0 mid-frame -> an=FF, seg=7F, dp=1 immediately (asynchronous). Release -> an stays FF for the first 64 cycles; frame_start pulses one cycle after the 8th tick.
- Scan order: digits=32'h76543210, masks 0 -> after the first snapshot, an steps FE,FD,FB,...,7F, each held 8 cycles. seg for digit 0 = 01, digit 3 = 06, digit 7 = 0F. Exactly one anode is low in every cycle.
- Tearing: change digits from 32'h00000000 to 32'h88888888 while idx=3 -> digits 4..7 still show 0 (seg=01) for the rest of that frame; the next frame shows 8 (seg=00) on all digits.
- Masks: dp_mask=8'h04, blank_mask=8'h80 -> dp=0 only while an=FB; an never equals 7F; all other digits are driven.
- Blink: raise blink_en -> display visible 40 cycles, dark 40, visible 40. Scan idx keeps advancing throughout. Drop blink_en while dark -> display visible on the next cycle.
- Hex table: sweep digit 0 through 0..F across 16 frames -> seg matches the HEX2SEG table for every value.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants for the eight-digit common-anode scanner:
// active-low segment decode table and idle levels.
package seg7_pkg;

  localparam int N_DIGITS = 8;

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [7:0] AN_OFF  = 8'hFF;

  // {a,b,c,d,e,f,g}, a segment is lit when its bit is 0
  localparam logic [6:0] HEX2SEG [16] = '{
    7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
    7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38
  };

  function automatic logic [7:0] an_select(input logic [2:0] idx);
    logic [7:0] one_hot;
    one_hot = 8'h01 << idx;
    return ~one_hot;
  endfunction

endpackage

// File: rtl/seg7_scan_tick_gen.sv
// Free-running divider: tick is high for one cycle every PERIOD cycles;
// clr parks the counter at zero and suppresses the tick.
module tick_gen #(
  parameter int PERIOD = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  output logic tick
);

  localparam int W = $clog2(PERIOD) + 1;
  localparam logic [W-1:0] LAST = W'(PERIOD - 1);

  generate
    if (PERIOD < 1) begin : g_bad_period
      $error("tick_gen: PERIOD must be at least 1");
    end
  endgenerate

  logic [W-1:0] cnt_reg;

  assign tick = !clr && (cnt_reg == LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_reg <= '0;
    end else if (clr || tick) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + W'(1);
    end
  end

endmodule

// File: rtl/seg7_scan.sv
// Time-multiplexed driver for eight common-anode digits with per-frame
// input snapshot and whole-display blinking.
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int CLK_HZ   = 100_000_000,
  parameter int SCAN_HZ  = 1000,
  parameter int BLINK_HZ = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] digits,
  input  logic [7:0]  dp_mask,
  input  logic [7:0]  blank_mask,
  input  logic        blink_en,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [7:0]  an,
  output logic        frame_start
);

  localparam int DIV  = CLK_HZ / SCAN_HZ - 1;
  localparam int HALF = CLK_HZ / (2 * BLINK_HZ);

  generate
    if ((CLK_HZ % SCAN_HZ) != 0 || DIV < 1) begin : g_bad_scan
      $error("seg7_scan: CLK_HZ must be a multiple of SCAN_HZ with DIV >= 1");
    end
    if ((CLK_HZ % (2 * BLINK_HZ)) != 0) begin : g_bad_blink
      $error("seg7_scan: CLK_HZ must be a multiple of 2*BLINK_HZ");
    end
  endgenerate

  logic scan_tick;
  logic blink_tick;

  tick_gen #(.PERIOD(DIV + 1)) u_scan_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (1'b0),
    .tick    (scan_tick)
  );

  tick_gen #(.PERIOD(HALF)) u_blink_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (~blink_en),
    .tick    (blink_tick)
  );

  logic [2:0]  idx_reg;
  logic [31:0] shadow_digits_reg;
  logic [7:0]  shadow_dp_reg;
  logic [7:0]  shadow_blank_reg;
  logic        blink_phase_reg;
  logic        wrap_reg;
  logic [7:0]  an_reg;
  logic [6:0]  seg_reg;
  logic        dp_reg;
  logic        frame_start_reg;

  logic        dark;
  logic [3:0]  code;
  logic [7:0]  an_next;
  logic [6:0]  seg_next;
  logic        dp_next;

  // Anode and segments come from one decode so they always switch together.
  always_comb begin
    dark     = shadow_blank_reg[idx_reg] | (blink_en & blink_phase_reg);
    code     = shadow_digits_reg[{idx_reg, 2'b00} +: 4];
    an_next  = AN_OFF;
    seg_next = SEG_OFF;
    dp_next  = 1'b1;
    if (!dark) begin
      an_next  = an_select(idx_reg);
      seg_next = HEX2SEG[code];
      dp_next  = ~shadow_dp_reg[idx_reg];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx_reg           <= '0;
      shadow_digits_reg <= '0;
      shadow_dp_reg     <= '0;
      shadow_blank_reg  <= AN_OFF;
      blink_phase_reg   <= 1'b0;
      wrap_reg          <= 1'b0;
      an_reg            <= AN_OFF;
      seg_reg           <= SEG_OFF;
      dp_reg            <= 1'b1;
      frame_start_reg   <= 1'b0;
    end else begin
      if (scan_tick) begin
        idx_reg <= idx_reg + 3'd1;
        // Snapshot at the frame boundary so a frame never mixes two inputs.
        if (idx_reg == 3'(N_DIGITS - 1)) begin
          shadow_digits_reg <= digits;
          shadow_dp_reg     <= dp_mask;
          shadow_blank_reg  <= blank_mask;
        end
      end
      if (!blink_en) begin
        blink_phase_reg <= 1'b0;
      end else if (blink_tick) begin
        blink_phase_reg <= ~blink_phase_reg;
      end
      // Delayed twice: once for idx to reach 0, once for the output register.
      wrap_reg        <= scan_tick && (idx_reg == 3'(N_DIGITS - 1));
      frame_start_reg <= wrap_reg;
      an_reg          <= an_next;
      seg_reg         <= seg_next;
      dp_reg          <= dp_next;
    end
  end

  assign an          = an_reg;
  assign seg         = seg_reg;
  assign dp          = dp_reg;
  assign frame_start = frame_start_reg;

endmodule

// File: tb/tb_seg7_scan.sv
// Self-checking bench for seg7_scan at CLK_HZ=800, SCAN_HZ=100, BLINK_HZ=10
// (8 cycles per digit, 64-cycle frames, 40-cycle blink half-period).
module tb_seg7_scan;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [31:0] digits = 32'h0;
  logic [7:0]  dp_mask = 8'h0;
  logic [7:0]  blank_mask = 8'h0;
  logic        blink_en = 1'b0;
  logic [6:0]  seg;
  logic        dp;
  logic [7:0]  an;
  logic        frame_start;

  always #5 clk = ~clk;

  seg7_scan #(.CLK_HZ(800), .SCAN_HZ(100), .BLINK_HZ(10)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .digits      (digits),
    .dp_mask     (dp_mask),
    .blank_mask  (blank_mask),
    .blink_en    (blink_en),
    .seg         (seg),
    .dp          (dp),
    .an          (an),
    .frame_start (frame_start)
  );

  typedef struct packed {
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
  } disp_t;

  typedef struct {
    logic [31:0] digits;
    logic [7:0]  dp_mask;
    logic [7:0]  blank_mask;
    int          at;
  } vec_t;

  logic [6:0] hex_tbl [16] = '{
    7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
    7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38
  };

  int    checks = 0;
  int    errors = 0;
  disp_t sb[$];
  vec_t  vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit an_ok(input logic [7:0] a);
    return (a == 8'hFF) || ($countones(~a) == 1);
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Expected display for one frame, in digit order 0..7
  task automatic push_frame(input logic [31:0] d, input logic [7:0] dpm, input logic [7:0] blm);
    for (int k = 0; k < 8; k++) begin
      disp_t      e;
      logic [7:0] sel;
      logic [3:0] nib;
      sel = 8'h01 << k;
      nib = d[4*k +: 4];
      if (blm[k]) begin
        e.an = 8'hFF; e.seg = 7'h7F; e.dp = 1'b1;
      end else begin
        e.an = ~sel; e.seg = hex_tbl[nib]; e.dp = ~dpm[k];
      end
      sb.push_back(e);
    end
  endtask

  task automatic assert_reset(input string tag);
    #2 reset_n = 1'b0;
    #1;
    check({tag, "_an"}, an, 8'hFF);
    check({tag, "_seg"}, seg, 7'h7F);
    check({tag, "_dp"}, dp, 1'b1);
    check({tag, "_fs"}, frame_start, 1'b0);
    $display("reset asserted (%s)", tag);
  endtask

  // Release reset, expect a dark first frame, end at the first frame_start cycle.
  task automatic reset_sequence(input string tag);
    int         n = 0;
    int         first_fs = 0;
    int         dark_bad = 0;
    logic [7:0] an_at = 8'h00;
    step();
    step();
    reset_n = 1'b1;
    while (first_fs == 0 && n < 200) begin
      step();
      n++;
      if (n <= 64 && an !== 8'hFF) dark_bad++;
      if (frame_start === 1'b1) begin
        first_fs = n;
        an_at = an;
      end
    end
    check({tag, "_dark_first_frame"}, dark_bad, 0);
    check({tag, "_first_fs_cycle"}, first_fs, 65);
    check({tag, "_first_an"}, an_at, 8'hFE);
    $display("reset released (%s): first frame_start after %0d cycles", tag, first_fs);
  endtask

  task automatic first_frame_check();
    int bad = 0;
    for (int c = 0; c < 64; c++) begin
      if (!an_ok(an) || an == 8'hFF) bad++;
      if (c == 0)  begin check("scan_d0_an", an, 8'hFE); check("scan_d0_seg", seg, 7'h01); end
      if (c == 24) begin check("scan_d3_an", an, 8'hF7); check("scan_d3_seg", seg, 7'h06); end
      if (c == 56) begin check("scan_d7_an", an, 8'h7F); check("scan_d7_seg", seg, 7'h0F); end
      step();
    end
    check("scan_one_anode", bad, 0);
    check("scan_next_fs", frame_start, 1'b1);
    push_frame(32'h76543210, 8'h00, 8'h00);
    $display("first frame digits=76543210 scanned");
  endtask

  // Starts and ends on a frame_start cycle; inputs driven at v.at show next frame.
  task automatic run_frame(input vec_t v);
    disp_t cur;
    disp_t seen;
    disp_t act;
    int    onehot_bad = 0;
    int    fs_bad = 0;
    cur = '0;
    seen = '0;
    for (int c = 0; c < 64; c++) begin
      if (c == v.at) begin
        digits = v.digits;
        dp_mask = v.dp_mask;
        blank_mask = v.blank_mask;
        push_frame(v.digits, v.dp_mask, v.blank_mask);
      end
      if (c % 8 == 0) begin
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_underflow: got empty queue expected 8 entries");
          cur = '1;
        end else begin
          cur = sb.pop_front();
        end
        seen = cur;
      end
      act = {an, seg, dp};
      if (act !== cur) seen = act;
      if (!an_ok(an)) onehot_bad++;
      if (frame_start !== (c == 0)) fs_bad++;
      if (c % 8 == 7) check($sformatf("slot%0d", c / 8), seen, cur);
      step();
    end
    check("frame_one_anode", onehot_bad, 0);
    check("frame_start_pos", fs_bad, 0);
    $display("frame done: next digits=%h dp=%h blank=%h driven at c=%0d",
             v.digits, v.dp_mask, v.blank_mask, v.at);
  endtask

  task automatic blink_test();
    int vis1 = 0;
    int dark1 = 0;
    int vis2 = 0;
    blink_en = 1'b1;
    for (int n = 1; n <= 130; n++) begin
      step();
      if (n <= 40 && an !== 8'hFF) vis1++;
      if (n > 40 && n <= 80 && an === 8'hFF && seg === 7'h7F) dark1++;
      if (n > 80 && n <= 120 && an !== 8'hFF) vis2++;
      if (n == 64 || n == 128) check($sformatf("blink_fs_%0d", n), frame_start, 1'b1);
      if (n == 100) check("blink_scan_an", an, 8'hEF);
      if (n == 130) check("blink_dark_130", an, 8'hFF);
    end
    check("blink_visible1", vis1, 40);
    check("blink_dark1", dark1, 40);
    check("blink_visible2", vis2, 40);
    blink_en = 1'b0;
    step();
    check("blink_drop_an", an, 8'hFE);
    $display("blink: visible=%0d dark=%0d visible=%0d", vis1, dark1, vis2);
  endtask

  task automatic wait_fs();
    int n = 0;
    while (frame_start !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    check("wait_frame_start", frame_start, 1'b1);
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{32'h00000000, 8'h00, 8'h00, 0};
    vecs[1] = '{32'h88888888, 8'h00, 8'h00, 28};
    vecs[2] = '{32'hFEDCBA98, 8'h04, 8'h80, 0};
    vecs[3] = '{32'h12345678, 8'hFF, 8'h00, 0};
    vecs[4] = '{32'hA5C3E1F0, 8'h5A, 8'h24, 0};

    digits = 32'h76543210;
    assert_reset("init");
    reset_sequence("init");
    first_frame_check();

    for (int i = 0; i < 5; i++) run_frame(vecs[i]);

    for (int v = 0; v < 16; v++) begin
      vec_t hv;
      hv = '{32'(v), 8'h00, 8'h00, 0};
      run_frame(hv);
    end

    sb.delete();
    blink_test();
    wait_fs();

    repeat (20) step();
    check("pre_reset_an", an, 8'hFB);
    assert_reset("midframe");
    digits = 32'h76543210;
    dp_mask = 8'h00;
    blank_mask = 8'h00;
    reset_sequence("midframe");
    first_frame_check();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
